// File: rtl/line_proc_pkg.sv
// Shared types and constants for the line processing wrapper and its pixel datapath.
package line_proc_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_INV  = 2'd2,
        MODE_THR  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Luma weights; they sum to 256 so full-scale input maps to full-scale luma.
    localparam int unsigned LUMA_C0 = 77;
    localparam int unsigned LUMA_C1 = 150;
    localparam int unsigned LUMA_C2 = 29;

endpackage

// File: rtl/line_proc_wrapper_pixel_op.sv
// Two-stage pixel datapath: stage 1 registers the pixel and its luma, stage 2 applies the mode.
module pixel_op
    import line_proc_pkg::*;
#(
    parameter int unsigned CH     = 3,
    parameter int unsigned CH_W   = 8,
    parameter int unsigned THRESH = 128
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 IN_V,
    input  logic [CH*CH_W-1:0]   IN_PIX,
    input  mode_t                MODE,
    output logic                 OUT_V,
    output logic [CH*CH_W-1:0]   OUT_PIX
);
    localparam int unsigned PIX_W  = CH * CH_W;
    localparam int unsigned PROD_W = 2 * CH_W + 8;
    localparam int unsigned SUM_W  = 2 * CH_W + 10;

    logic [CH_W-1:0]   c0, c1, c2;
    logic [PROD_W-1:0] prod0, prod1, prod2;
    logic [SUM_W-1:0]  sum;
    logic [CH_W-1:0]   luma;
    logic              thr_hit;
    logic [PIX_W-1:0]  res;

    logic              v1_q, v2_q;
    logic [PIX_W-1:0]  pix1_q, pix2_q;
    logic [CH_W-1:0]   luma1_q;

    assign c0 = IN_PIX[PIX_W-1 -: CH_W];
    assign c1 = IN_PIX[PIX_W-1-CH_W -: CH_W];
    assign c2 = IN_PIX[PIX_W-1-2*CH_W -: CH_W];

    always_comb begin
        prod0 = PROD_W'(LUMA_C0) * PROD_W'(c0);
        prod1 = PROD_W'(LUMA_C1) * PROD_W'(c1);
        prod2 = PROD_W'(LUMA_C2) * PROD_W'(c2);
        sum   = SUM_W'(prod0) + SUM_W'(prod1) + SUM_W'(prod2);
        luma  = CH_W'(sum >> 8);
    end

    assign thr_hit = (luma1_q >= CH_W'(THRESH));

    // Only channels 0-2 carry colour; any further channels ride through gray/threshold untouched.
    always_comb begin
        res = pix1_q;
        case (MODE)
            MODE_GRAY: begin
                for (int unsigned c = 0; c < 3; c++) begin
                    res[PIX_W-1-c*CH_W -: CH_W] = luma1_q;
                end
            end
            MODE_INV: begin
                res = ~pix1_q;
            end
            MODE_THR: begin
                for (int unsigned c = 0; c < 3; c++) begin
                    res[PIX_W-1-c*CH_W -: CH_W] = {CH_W{thr_hit}};
                end
            end
            default: begin
                res = pix1_q;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            pix1_q  <= '0;
            pix2_q  <= '0;
            luma1_q <= '0;
        end else if (EN) begin
            v1_q <= IN_V;
            v2_q <= v1_q;
            if (IN_V) begin
                pix1_q  <= IN_PIX;
                luma1_q <= luma;
            end
            if (v1_q) begin
                pix2_q <= res;
            end
        end
    end

    assign OUT_V   = v2_q;
    assign OUT_PIX = pix2_q;

endmodule

// File: rtl/line_proc_wrapper.sv
// Line wrapper: one READ_LINE_DONE starts one line through pixel_op; OUT_READY stalls everything,
// and a trigger outside IDLE is dropped and recorded in the sticky OVERRUN flag.
module line_proc_wrapper
    import line_proc_pkg::*;
#(
    parameter int unsigned WIDTH  = 1600,
    parameter int unsigned POS_W  = 12,
    parameter int unsigned CH     = 3,
    parameter int unsigned CH_W   = 8,
    parameter int unsigned THRESH = 128
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   READ_LINE_DONE,
    input  logic [POS_W-1:0]       READ_POSY,
    input  logic [1:0]             MODE,
    output logic                   IN_DE,
    input  logic [CH*CH_W+7:0]     IN_DATA,
    input  logic                   OUT_READY,
    output logic                   OUT_DE,
    output logic [CH*CH_W+7:0]     OUT_DATA,
    output logic                   WRITE_LINE_DONE,
    output logic [POS_W-1:0]       LINE_Y,
    output logic                   BUSY,
    output logic                   OVERRUN
);
    localparam int unsigned PIX_W = CH * CH_W;

    state_t           state_q;
    mode_t            mode_q;
    logic [POS_W-1:0] rpos_q;
    logic [POS_W-1:0] wpos_q, wpos_d;
    logic [POS_W-1:0] line_y_q;
    logic             overrun_q, busy_q, wld_q;

    logic             in_de, out_v, out_de, rd_last, wr_full;
    logic [PIX_W-1:0] in_pix, out_pix;

    assign in_de   = (state_q == RUN) && (rpos_q < POS_W'(WIDTH)) && OUT_READY;
    assign out_de  = out_v && OUT_READY;
    assign wpos_d  = out_de ? wpos_q + POS_W'(1) : wpos_q;
    assign rd_last = in_de && (rpos_q == POS_W'(WIDTH - 1));
    // Looking at the next write count lets DONE follow the last output directly.
    assign wr_full = (wpos_d == POS_W'(WIDTH));
    assign in_pix  = PIX_W'(IN_DATA >> 8);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            mode_q    <= MODE_PASS;
            rpos_q    <= '0;
            wpos_q    <= '0;
            line_y_q  <= '0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
            wld_q     <= 1'b0;
        end else begin
            wld_q  <= 1'b0;
            wpos_q <= wpos_d;
            if (in_de) begin
                rpos_q <= rpos_q + POS_W'(1);
            end
            if (READ_LINE_DONE && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (READ_LINE_DONE) begin
                        line_y_q <= READ_POSY;
                        mode_q   <= mode_t'(MODE);
                        rpos_q   <= '0;
                        wpos_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (rd_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_full) begin
                        wld_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    pixel_op #(
        .CH     (CH),
        .CH_W   (CH_W),
        .THRESH (THRESH)
    ) u_pixel_op (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (OUT_READY),
        .IN_V    (in_de),
        .IN_PIX  (in_pix),
        .MODE    (mode_q),
        .OUT_V   (out_v),
        .OUT_PIX (out_pix)
    );

    assign IN_DE           = in_de;
    assign OUT_DE          = out_de;
    assign OUT_DATA        = {out_pix, 8'hff};
    assign WRITE_LINE_DONE = wld_q;
    assign LINE_Y          = line_y_q;
    assign BUSY            = busy_q;
    assign OVERRUN         = overrun_q;

endmodule

// File: tb/tb_line_proc_wrapper.sv
// Directed bench for line_proc_wrapper with a cycle-level reference model checked every cycle.
module tb_line_proc_wrapper;
    localparam int unsigned W      = 16;
    localparam int unsigned POS_W  = 12;
    localparam int unsigned CH     = 3;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned THRESH = 128;
    localparam int unsigned DW     = CH * CH_W + 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             READ_LINE_DONE;
    logic [POS_W-1:0] READ_POSY;
    logic [1:0]       MODE;
    logic             IN_DE;
    logic [DW-1:0]    IN_DATA;
    logic             OUT_READY;
    logic             OUT_DE;
    logic [DW-1:0]    OUT_DATA;
    logic             WRITE_LINE_DONE;
    logic [POS_W-1:0] LINE_Y;
    logic             BUSY;
    logic             OVERRUN;

    line_proc_wrapper #(
        .WIDTH  (W),
        .POS_W  (POS_W),
        .CH     (CH),
        .CH_W   (CH_W),
        .THRESH (THRESH)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .READ_LINE_DONE  (READ_LINE_DONE),
        .READ_POSY       (READ_POSY),
        .MODE            (MODE),
        .IN_DE           (IN_DE),
        .IN_DATA         (IN_DATA),
        .OUT_READY       (OUT_READY),
        .OUT_DE          (OUT_DE),
        .OUT_DATA        (OUT_DATA),
        .WRITE_LINE_DONE (WRITE_LINE_DONE),
        .LINE_Y          (LINE_Y),
        .BUSY            (BUSY),
        .OVERRUN         (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [23:0]      src_mem [W];
    int               rd_ptr = 0;

    bit               line_valid = 1'b0;
    int               trig = 0, exp_done = 0, in_cnt = 0, out_idx = 0, rc = 0;
    int               rq[$];
    logic [23:0]      exp_pix [W];
    logic [23:0]      outs [W];
    bit               ovr_m = 1'b0;
    logic [POS_W-1:0] posy_m = '0;
    int               wld_cnt = 0, wld_cyc = 0;
    int               last_trig = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] model_op(input logic [23:0] p, input logic [1:0] m);
        int r, g, b, y;
        logic [7:0] y8;
        r  = int'(p[23:16]);
        g  = int'(p[15:8]);
        b  = int'(p[7:0]);
        y  = (77 * r + 150 * g + 29 * b) / 256;
        y8 = 8'(y);
        case (m)
            2'd0:    return p;
            2'd1:    return {y8, y8, y8};
            2'd2:    return ~p;
            default: return (y >= int'(THRESH)) ? 24'hffffff : 24'h000000;
        endcase
    endfunction

    // FWFT source: the k-th read of a line always sees src_mem[k].
    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) rd_ptr <= in_cnt;
    assign IN_DATA = {src_mem[rd_ptr % W], 8'h5A};

    always @(negedge CLK) begin
        bit act, exp_in, exp_out;
        if (RST) begin
            chk("rst_in_de", 64'(IN_DE), 64'd0);
            chk("rst_out_de", 64'(OUT_DE), 64'd0);
            chk("rst_wld", 64'(WRITE_LINE_DONE), 64'd0);
            chk("rst_busy", 64'(BUSY), 64'd0);
            chk("rst_overrun", 64'(OVERRUN), 64'd0);
            chk("rst_line_y", 64'(LINE_Y), 64'd0);
            chk("rst_out_data", 64'(OUT_DATA), 64'h0000_00ff);
            line_valid = 1'b0;
            ovr_m      = 1'b0;
            in_cnt     = 0;
            rq.delete();
        end else begin
            act     = line_valid && (cyc <= exp_done);
            exp_in  = act && (cyc > trig) && (in_cnt < int'(W)) && OUT_READY;
            exp_out = act && OUT_READY && (rq.size() > 0) && (rq[0] + 2 == rc);
            chk("in_de", 64'(IN_DE), 64'(exp_in));
            chk("out_de", 64'(OUT_DE), 64'(exp_out));
            chk("wld", 64'(WRITE_LINE_DONE), 64'(act && (cyc == exp_done)));
            chk("busy", 64'(BUSY), 64'(act && (cyc > trig)));
            chk("overrun", 64'(OVERRUN), 64'(ovr_m));
            if (WRITE_LINE_DONE) begin
                wld_cnt++;
                wld_cyc = cyc;
            end
            if (exp_out) begin
                if (OUT_DE && out_idx < int'(W)) begin
                    chk("out_data", 64'(OUT_DATA), 64'({exp_pix[out_idx], 8'hff}));
                    outs[out_idx] = OUT_DATA[DW-1:8];
                end
                out_idx++;
                void'(rq.pop_front());
            end
            if (exp_in) begin
                rq.push_back(rc);
                in_cnt++;
            end
            if (act && (cyc == exp_done)) begin
                chk("line_y", 64'(LINE_Y), 64'(posy_m));
            end
            if (act && (cyc > trig) && (cyc < exp_done) && !OUT_READY) exp_done++;
            if (OUT_READY) rc++;
            if (READ_LINE_DONE) begin
                if (act) begin
                    ovr_m = 1'b1;
                end else begin
                    line_valid = 1'b1;
                    trig       = cyc;
                    exp_done   = cyc + int'(W) + 3;
                    in_cnt     = 0;
                    out_idx    = 0;
                    posy_m     = READ_POSY;
                    rq.delete();
                    for (int i = 0; i < int'(W); i++) begin
                        exp_pix[i] = model_op(src_mem[i], MODE);
                        outs[i]    = 24'hxxxxxx;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic trigger(input logic [POS_W-1:0] y, input logic [1:0] m);
        last_trig      = cyc;
        READ_LINE_DONE = 1'b1;
        READ_POSY      = y;
        MODE           = m;
        tick(1);
        READ_LINE_DONE = 1'b0;
        MODE           = ~m;
    endtask

    task automatic wait_line_end(input string name);
        int n;
        n = 0;
        while (line_valid && (cyc <= exp_done) && n < 100) begin
            tick(1);
            n++;
        end
        tick(1);
        chk({name, "_timeout"}, 64'(n >= 100), 64'd0);
        chk({name, "_count"}, 64'(out_idx), 64'(W));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, wld_before;
        RST            = 1'b1;
        READ_LINE_DONE = 1'b0;
        READ_POSY      = '0;
        MODE           = 2'd0;
        OUT_READY      = 1'b1;
        src_mem[0] = 24'hC86432;
        src_mem[1] = 24'h808080;
        src_mem[2] = 24'h7F7F7F;
        src_mem[3] = 24'hFFFFFF;
        src_mem[4] = 24'h000000;
        for (int i = 5; i < int'(W); i++) begin
            src_mem[i] = {8'(i * 23), 8'(i * 41 + 7), 8'(255 - i * 13)};
        end
        tick(3);
        RST = 1'b0;
        tick(2);

        trigger(12'd5, 2'd0);
        t0 = last_trig;
        wait_line_end("pass");
        chk("pass_wld_cyc", 64'(wld_cyc - t0), 64'd19);
        chk("pass_px0", 64'(outs[0]), 64'hC86432);
        chk("pass_px3", 64'(outs[3]), 64'hFFFFFF);
        chk("pass_line_y", 64'(LINE_Y), 64'd5);

        trigger(12'd6, 2'd1);
        wait_line_end("gray");
        chk("gray_px0", 64'(outs[0]), 64'h7C7C7C);
        chk("gray_px1", 64'(outs[1]), 64'h808080);
        chk("gray_px2", 64'(outs[2]), 64'h7F7F7F);
        chk("gray_px3", 64'(outs[3]), 64'hFFFFFF);

        trigger(12'd7, 2'd3);
        wait_line_end("thr");
        chk("thr_px0", 64'(outs[0]), 64'h000000);
        chk("thr_px1", 64'(outs[1]), 64'hFFFFFF);
        chk("thr_px2", 64'(outs[2]), 64'h000000);
        chk("thr_px3", 64'(outs[3]), 64'hFFFFFF);

        trigger(12'd8, 2'd2);
        t0 = last_trig;
        tick(5);
        OUT_READY = 1'b0;
        tick(3);
        OUT_READY = 1'b1;
        wait_line_end("inv");
        chk("inv_wld_cyc", 64'(wld_cyc - t0), 64'd22);
        chk("inv_px0", 64'(outs[0]), 64'h379BCD);
        chk("inv_ovr", 64'(OVERRUN), 64'd0);

        trigger(12'd9, 2'd0);
        t0 = last_trig;
        tick(18);
        READ_LINE_DONE = 1'b1;
        READ_POSY      = 12'd10;
        MODE           = 2'd2;
        tick(1);
        READ_POSY      = 12'd11;
        MODE           = 2'd1;
        tick(1);
        READ_LINE_DONE = 1'b0;
        MODE           = 2'd0;
        chk("ovr_first_wld", 64'(wld_cyc - t0), 64'd19);
        t0 = t0 + 20;
        tick(5);
        trigger(12'd12, 2'd3);
        wait_line_end("ovr");
        chk("ovr_second_wld", 64'(wld_cyc - t0), 64'd19);
        chk("ovr_line_y", 64'(LINE_Y), 64'd11);
        chk("ovr_px0", 64'(outs[0]), 64'h7C7C7C);
        chk("ovr_sticky", 64'(OVERRUN), 64'd1);

        wld_before = wld_cnt;
        trigger(12'd13, 2'd2);
        tick(7);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(2);
        chk("abort_no_wld", 64'(wld_cnt), 64'(wld_before));
        chk("abort_ovr_clr", 64'(OVERRUN), 64'd0);
        trigger(12'd14, 2'd0);
        t0 = last_trig;
        wait_line_end("after_rst");
        chk("after_rst_wld", 64'(wld_cyc - t0), 64'd19);
        chk("after_rst_px3", 64'(outs[3]), 64'hFFFFFF);
        chk("total_lines", 64'(wld_cnt), 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
